// File: rtl/mips16_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mips16_pkg : shared encodings for the MIPS16 multi-cycle controller
// Revision   : 1.0
// ============================================================================
package mips16_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_IEXEC  = 4'd8,
      S_IWB    = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   localparam logic [3:0] c_op_rtype = 4'b0000;
   localparam logic [3:0] c_op_lw    = 4'b0001;
   localparam logic [3:0] c_op_sw    = 4'b0010;
   localparam logic [3:0] c_op_beq   = 4'b0011;
   localparam logic [3:0] c_op_addi  = 4'b0100;
   localparam logic [3:0] c_op_slti  = 4'b0101;
   localparam logic [3:0] c_op_j     = 4'b0110;
   localparam logic [3:0] c_op_halt  = 4'b0111;

   localparam logic [1:0] c_aluop_funct = 2'b00;
   localparam logic [1:0] c_aluop_sub   = 2'b01;
   localparam logic [1:0] c_aluop_opc   = 2'b10;
   localparam logic [1:0] c_aluop_add   = 2'b11;

   localparam logic [1:0] c_srcb_regb = 2'b00;
   localparam logic [1:0] c_srcb_one  = 2'b01;
   localparam logic [1:0] c_srcb_imm  = 2'b10;
   localparam logic [1:0] c_srcb_boff = 2'b11;

   localparam logic [1:0] c_pcsrc_alu    = 2'b00;
   localparam logic [1:0] c_pcsrc_aluout = 2'b01;
   localparam logic [1:0] c_pcsrc_jump   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic       halted;
   } ctrl_t;

   localparam ctrl_t c_ctrl_idle = '0;

   function automatic logic is_illegal(input logic [3:0] op);
      return op[3];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips16_mc_outdec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mips16_mc_outdec : Moore output decode of the multi-cycle controller
// Revision         : 1.0
// ============================================================================
module mips16_mc_outdec
   import mips16_pkg::*;
(
   input  state_t     state,
   input  logic [3:0] op,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = c_ctrl_idle;
      case (state)
         S_FETCH: begin
            // Only the IR/PC strobes see mem_ready; everything else is pure Moore
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = c_srcb_one;
            ctrl.alu_op    = c_aluop_add;
            ctrl.pc_source = c_pcsrc_alu;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = c_srcb_boff;
            ctrl.alu_op    = c_aluop_add;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = c_srcb_imm;
            ctrl.alu_op    = c_aluop_add;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = c_srcb_regb;
            ctrl.alu_op    = c_aluop_funct;
         end
         S_RWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_IEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = c_srcb_imm;
            ctrl.alu_op    = (op == c_op_slti) ? c_aluop_opc : c_aluop_add;
         end
         S_IWB: begin
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = c_srcb_regb;
            ctrl.alu_op        = c_aluop_sub;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = c_pcsrc_aluout;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = c_pcsrc_jump;
         end
         S_HALT: begin
            ctrl.halted = 1'b1;
         end
         default: ctrl = c_ctrl_idle;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mips16_mc_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mips16_mc_control : multi-cycle MIPS16 main control FSM
// Revision          : 1.0
// ============================================================================
module mips16_mc_control
   import mips16_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [1:0] alu_op,
   output logic       halted,
   output logic       illegal
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_op;
   logic       r_illegal;
   ctrl_t      w_ctrl;
   ctrl_t      w_ctrl_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op      <= c_op_rtype;
         r_illegal <= 1'b0;
      end else if (r_state == S_DECODE) begin
         r_op <= opcode;
         if (is_illegal(opcode)) begin
            r_illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               c_op_rtype:           w_next = S_EXEC;
               c_op_lw, c_op_sw:     w_next = S_MEMADR;
               c_op_beq:             w_next = S_BRANCH;
               c_op_addi, c_op_slti: w_next = S_IEXEC;
               c_op_j:               w_next = S_JUMP;
               c_op_halt:            w_next = S_HALT;
               default:              w_next = S_FETCH;
            endcase
         end
         S_MEMADR: w_next = (r_op == c_op_lw) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  w_next = S_FETCH;
         S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   w_next = S_RWB;
         S_RWB:    w_next = S_FETCH;
         S_IEXEC:  w_next = S_IWB;
         S_IWB:    w_next = S_FETCH;
         S_BRANCH: w_next = S_FETCH;
         S_JUMP:   w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   mips16_mc_outdec u_outdec (
      .state     (r_state),
      .op        (r_op),
      .mem_ready (mem_ready),
      .ctrl      (w_ctrl)
   );

   // Reset is asynchronous, so FETCH's mem_read must not leak while it is held
   assign w_ctrl_out = reset ? c_ctrl_idle : w_ctrl;

   assign pc_write      = w_ctrl_out.pc_write;
   assign pc_write_cond = w_ctrl_out.pc_write_cond;
   assign iord          = w_ctrl_out.iord;
   assign mem_read      = w_ctrl_out.mem_read;
   assign mem_write     = w_ctrl_out.mem_write;
   assign ir_write      = w_ctrl_out.ir_write;
   assign mem_to_reg    = w_ctrl_out.mem_to_reg;
   assign reg_dst       = w_ctrl_out.reg_dst;
   assign reg_write     = w_ctrl_out.reg_write;
   assign alu_src_a     = w_ctrl_out.alu_src_a;
   assign alu_src_b     = w_ctrl_out.alu_src_b;
   assign pc_source     = w_ctrl_out.pc_source;
   assign alu_op        = w_ctrl_out.alu_op;
   assign halted        = w_ctrl_out.halted;
   assign illegal       = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mips16_mc_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mips16_mc_control : self-checking bench, per-instruction trace model
// Revision             : 1.0
// ============================================================================
module tb_mips16_mc_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, halted, illegal;
   logic [1:0] alu_src_b, pc_source, alu_op;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [17:0] exp;
      logic        mr;
      logic        dec;
      logic [3:0]  op;
   } step_t;

   step_t       trace[$];
   logic [17:0] obs[$];
   logic        model_ill;

   mips16_mc_control dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .pc_source     (pc_source),
      .alu_op        (alu_op),
      .halted        (halted),
      .illegal       (illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] cw(
      input logic pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa,
      input logic [1:0] asb, psrc, aop,
      input logic hlt, ill);
      return {pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, psrc, aop, hlt, ill};
   endfunction

   function automatic logic [17:0] sample_outputs();
      return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
              alu_op, halted, illegal};
   endfunction

   task automatic push(input logic [17:0] e, input logic mr, input logic dec, input logic [3:0] op);
      step_t s;
      s.exp = e; s.mr = mr; s.dec = dec; s.op = op;
      trace.push_back(s);
   endtask

   // Expected per-cycle outputs of one instruction; wf/wm are not-ready cycles
   // inserted in the fetch and data-memory waits respectively.
   task automatic add_instr(input logic [3:0] op, input int wf, input int wm);
      logic r;
      for (int i = 0; i < wf; i++)
         push(cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b11,0,model_ill), 1'b0, 1'b0, op);
      push(cw(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b11,0,model_ill), 1'b1, 1'b0, op);
      r = 1'($urandom_range(0, 1));
      push(cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b11,0,model_ill), r, 1'b1, op);
      if (op[3]) begin
         model_ill = 1'b1;
         return;
      end
      case (op)
         4'd0: begin
            push(cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0,model_ill), 1'($urandom_range(0,1)), 1'b0, op);
            push(cw(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,model_ill), 1'($urandom_range(0,1)), 1'b0, op);
         end
         4'd1, 4'd2: begin
            push(cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b11,0,model_ill), 1'($urandom_range(0,1)), 1'b0, op);
            for (int i = 0; i <= wm; i++) begin
               if (op == 4'd1)
                  push(cw(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,model_ill), (i == wm), 1'b0, op);
               else
                  push(cw(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,model_ill), (i == wm), 1'b0, op);
            end
            if (op == 4'd1)
               push(cw(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,model_ill), 1'($urandom_range(0,1)), 1'b0, op);
         end
         4'd3: push(cw(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,model_ill), 1'($urandom_range(0,1)), 1'b0, op);
         4'd4, 4'd5: begin
            push(cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,(op == 4'd5) ? 2'b10 : 2'b11,0,model_ill),
                 1'($urandom_range(0,1)), 1'b0, op);
            push(cw(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,model_ill), 1'($urandom_range(0,1)), 1'b0, op);
         end
         4'd6: push(cw(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0,model_ill), 1'($urandom_range(0,1)), 1'b0, op);
         default: begin
            for (int i = 0; i < 20; i++)
               push(cw(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,model_ill), 1'($urandom_range(0,1)), 1'b0, op);
         end
      endcase
   endtask

   // Pure driver: entered and left at posedge+1, samples at the falling edge
   task automatic run_trace();
      obs.delete();
      foreach (trace[i]) begin
         mem_ready = trace[i].mr;
         opcode    = trace[i].dec ? trace[i].op : 4'($urandom_range(0, 15));
         @(negedge clk);
         obs.push_back(sample_outputs());
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_ready = 1'b1; opcode = 4'd1; model_ill = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (sample_outputs() !== 18'd0) begin
            failures++;
            $display("FAIL reset_hold cyc %0d: got %b expected %b", i, sample_outputs(), 18'd0);
         end
      end
      mem_ready = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if (sample_outputs() !== cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b11,0,0)) begin
         failures++;
         $display("FAIL reset_release: got %b expected %b", sample_outputs(),
                  cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b11,0,0));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_lw();
      trace.delete();
      add_instr(4'd1, 0, 0);
      run_trace();
      foreach (trace[i]) begin
         checks++;
         if (obs[i] !== trace[i].exp) begin
            failures++;
            $display("FAIL lw step %0d: got %b expected %b", i, obs[i], trace[i].exp);
         end
      end
   endtask

   task automatic test_sw_wait();
      int mw_cnt = 0;
      int rw_cnt = 0;
      trace.delete();
      add_instr(4'd2, 0, 3);
      run_trace();
      foreach (trace[i]) begin
         checks++;
         if (obs[i] !== trace[i].exp) begin
            failures++;
            $display("FAIL sw_wait step %0d: got %b expected %b", i, obs[i], trace[i].exp);
         end
         mw_cnt += int'(obs[i][13]);
         rw_cnt += int'(obs[i][9]);
      end
      checks++;
      if (mw_cnt != 4) begin
         failures++;
         $display("FAIL sw_wait mem_write cycles: got %0d expected 4", mw_cnt);
      end
      checks++;
      if (rw_cnt != 0) begin
         failures++;
         $display("FAIL sw_wait reg_write cycles: got %0d expected 0", rw_cnt);
      end
   endtask

   task automatic test_rtype_slti();
      trace.delete();
      add_instr(4'd0, 1, 0);
      add_instr(4'd5, 0, 0);
      add_instr(4'd4, 0, 0);
      run_trace();
      foreach (trace[i]) begin
         checks++;
         if (obs[i] !== trace[i].exp) begin
            failures++;
            $display("FAIL rtype_slti step %0d: got %b expected %b", i, obs[i], trace[i].exp);
         end
      end
   endtask

   task automatic test_illegal();
      trace.delete();
      add_instr(4'b1010, 0, 0);
      add_instr(4'd1, 0, 1);
      add_instr(4'd3, 0, 0);
      run_trace();
      foreach (trace[i]) begin
         checks++;
         if (obs[i] !== trace[i].exp) begin
            failures++;
            $display("FAIL illegal step %0d: got %b expected %b", i, obs[i], trace[i].exp);
         end
      end
      checks++;
      if (illegal !== 1'b1) begin
         failures++;
         $display("FAIL illegal_sticky: got %b expected 1", illegal);
      end
   endtask

   task automatic test_mid_reset();
      trace.delete();
      add_instr(4'd1, 1, 3);
      while (trace.size() > 6) void'(trace.pop_back());
      run_trace();
      foreach (trace[i]) begin
         checks++;
         if (obs[i] !== trace[i].exp) begin
            failures++;
            $display("FAIL mid_reset_pre step %0d: got %b expected %b", i, obs[i], trace[i].exp);
         end
      end
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (sample_outputs() !== 18'd0) begin
         failures++;
         $display("FAIL mid_reset_abort: got %b expected %b", sample_outputs(), 18'd0);
      end
      model_ill = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (sample_outputs() !== cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b11,0,0)) begin
         failures++;
         $display("FAIL mid_reset_fetch: got %b expected %b", sample_outputs(),
                  cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b11,0,0));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [3:0] op;
      trace.delete();
      for (int n = 0; n < 40; n++) begin
         do op = 4'($urandom_range(0, 15)); while (op == 4'd7);
         add_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      run_trace();
      foreach (trace[i]) begin
         checks++;
         if (obs[i] !== trace[i].exp) begin
            failures++;
            $display("FAIL random step %0d op %0d: got %b expected %b", i, trace[i].op, obs[i], trace[i].exp);
         end
      end
   endtask

   task automatic test_halt();
      trace.delete();
      add_instr(4'd7, 0, 0);
      run_trace();
      foreach (trace[i]) begin
         checks++;
         if (obs[i] !== trace[i].exp) begin
            failures++;
            $display("FAIL halt step %0d: got %b expected %b", i, obs[i], trace[i].exp);
         end
      end
      reset = 1'b1;
      #1;
      checks++;
      if (sample_outputs() !== 18'd0) begin
         failures++;
         $display("FAIL halt_reset: got %b expected %b", sample_outputs(), 18'd0);
      end
      model_ill = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (sample_outputs() !== cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b11,0,0)) begin
         failures++;
         $display("FAIL halt_release: got %b expected %b", sample_outputs(),
                  cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b11,0,0));
      end
      @(posedge clk);
      #1;
      trace.delete();
      add_instr(4'd6, 0, 0);
      run_trace();
      foreach (trace[i]) begin
         checks++;
         if (obs[i] !== trace[i].exp) begin
            failures++;
            $display("FAIL post_halt step %0d: got %b expected %b", i, obs[i], trace[i].exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_wait();
      test_rtype_slti();
      test_illegal();
      test_mid_reset();
      test_random();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
